// File: rtl/btb_update_ctrl.sv
// BTB write-port update scheduler: round-robin arbitration of two resolution
// sources into an in-order FIFO, drained at most one registered update per cycle.
module btb_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [XLEN-1:0]          a_pc,
  input  logic [XLEN-1:0]          a_target,
  input  logic                     a_mispred,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [XLEN-1:0]          b_pc,
  input  logic [XLEN-1:0]          b_target,
  input  logic                     b_mispred,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     update,
  output logic [XLEN-1:0]          updatePC,
  output logic [XLEN-1:0]          updateTarget,
  output logic                     mispredicted,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * XLEN + 1;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_prio;   // 0: A has priority, 1: B has priority
  logic            r_update;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_target;
  logic            r_mispred;

  logic            w_free_ge2;
  logic            w_free_one;
  logic            w_a_acc;
  logic            w_b_acc;
  logic            w_pri_acc;
  logic            w_oth_acc;
  logic [EW-1:0]   w_pri_entry;
  logic [EW-1:0]   w_oth_entry;
  logic [PW-1:0]   w_oth_slot;
  logic [1:0]      w_npush;
  logic            w_pop;

  // Readiness uses only the registered occupancy, so a same-cycle pop never
  // feeds back into ready.
  assign w_free_ge2 = (r_count <= CW'(DEPTH - 2));
  assign w_free_one = (r_count == CW'(DEPTH - 1));

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!flush) begin
      if (w_free_ge2) begin
        a_ready = 1'b1;
        b_ready = 1'b1;
      end else if (w_free_one) begin
        if (!r_prio) begin
          a_ready = 1'b1;
          b_ready = !a_valid;
        end else begin
          b_ready = 1'b1;
          a_ready = !b_valid;
        end
      end
    end
  end

  assign w_a_acc     = a_valid && a_ready;
  assign w_b_acc     = b_valid && b_ready;
  assign w_pri_acc   = r_prio ? w_b_acc : w_a_acc;
  assign w_oth_acc   = r_prio ? w_a_acc : w_b_acc;
  assign w_pri_entry = r_prio ? {b_pc, b_target, b_mispred} : {a_pc, a_target, a_mispred};
  assign w_oth_entry = r_prio ? {a_pc, a_target, a_mispred} : {b_pc, b_target, b_mispred};
  // The priority requester's entry is older, so the other one lands behind it.
  assign w_oth_slot  = r_wptr + PW'(w_pri_acc);
  assign w_npush     = {1'b0, w_pri_acc} + {1'b0, w_oth_acc};
  assign w_pop       = (r_count != '0) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (w_pri_acc) r_mem[r_wptr]     <= w_pri_entry;
    if (w_oth_acc) r_mem[w_oth_slot] <= w_oth_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_prio    <= 1'b0;
      r_update  <= 1'b0;
      r_pc      <= '0;
      r_target  <= '0;
      r_mispred <= 1'b0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_update <= 1'b0;
    end else begin
      r_wptr   <= r_wptr + PW'(w_npush);
      r_rptr   <= r_rptr + PW'(w_pop);
      r_count  <= r_count + CW'(w_npush) - CW'(w_pop);
      r_update <= w_pop;
      if (w_pop) {r_pc, r_target, r_mispred} <= r_mem[r_rptr];
      if (w_pri_acc) r_prio <= ~r_prio;
    end
  end

  assign update       = r_update;
  assign updatePC     = r_pc;
  assign updateTarget = r_target;
  assign mispredicted = r_mispred;
  assign count        = r_count;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_btb_update_ctrl;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, a_ready, a_mispred;
  logic [XLEN-1:0] a_pc, a_target;
  logic            b_valid, b_ready, b_mispred;
  logic [XLEN-1:0] b_pc, b_target;
  logic            stall, flush;
  logic            update, mispredicted;
  logic [XLEN-1:0] updatePC, updateTarget;
  logic [2:0]      count;

  int n_vec = 0;
  int n_err = 0;

  btb_update_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_pc(a_pc), .a_target(a_target), .a_mispred(a_mispred),
    .b_valid(b_valid), .b_ready(b_ready), .b_pc(b_pc), .b_target(b_target), .b_mispred(b_mispred),
    .stall(stall), .flush(flush),
    .update(update), .updatePC(updatePC), .updateTarget(updateTarget),
    .mispredicted(mispredicted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: occupancy is the queue size, entries leave in arrival order.
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            m;
  } ent_t;

  ent_t            q[$];
  ent_t            m_head;
  logic            m_prio;
  logic            m_upd, m_mis;
  logic [XLEN-1:0] m_pc, m_tgt;
  int              m_free;
  logic            e_ar, e_br, e_aacc, e_bacc, e_pop;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_prio = 1'b0;
      m_upd  = 1'b0;
      m_pc   = '0;
      m_tgt  = '0;
      m_mis  = 1'b0;
      check("rst_update", 64'(update), 64'd0);
      check("rst_count", 64'(count), 64'd0);
    end else begin
      m_free = DEPTH - q.size();
      e_ar = 1'b0;
      e_br = 1'b0;
      if (!flush) begin
        if (m_free >= 2) begin
          e_ar = 1'b1;
          e_br = 1'b1;
        end else if (m_free == 1) begin
          if (m_prio == 1'b0) begin
            e_ar = 1'b1;
            e_br = !a_valid;
          end else begin
            e_br = 1'b1;
            e_ar = !b_valid;
          end
        end
      end
      check("m_a_ready", 64'(a_ready), 64'(e_ar));
      check("m_b_ready", 64'(b_ready), 64'(e_br));
      check("m_update", 64'(update), 64'(m_upd));
      check("m_updatePC", 64'(updatePC), 64'(m_pc));
      check("m_updateTarget", 64'(updateTarget), 64'(m_tgt));
      check("m_mispredicted", 64'(mispredicted), 64'(m_mis));
      check("m_count", 64'(count), 64'(q.size()));

      e_aacc = a_valid && e_ar;
      e_bacc = b_valid && e_br;
      e_pop  = (q.size() > 0) && !stall && !flush;
      if (flush) begin
        q.delete();
        m_upd = 1'b0;
      end else begin
        m_upd = e_pop;
        if (e_pop) begin
          m_head = q.pop_front();
          m_pc   = m_head.pc;
          m_tgt  = m_head.tgt;
          m_mis  = m_head.m;
        end
        if (m_prio == 1'b0) begin
          if (e_aacc) q.push_back('{a_pc, a_target, a_mispred});
          if (e_bacc) q.push_back('{b_pc, b_target, b_mispred});
          if (e_aacc) m_prio = 1'b1;
        end else begin
          if (e_bacc) q.push_back('{b_pc, b_target, b_mispred});
          if (e_aacc) q.push_back('{a_pc, a_target, a_mispred});
          if (e_bacc) m_prio = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic m);
    a_valid = v; a_pc = pc; a_target = tgt; a_mispred = m;
  endtask

  task automatic drv_b(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic m);
    b_valid = v; b_pc = pc; b_target = tgt; b_mispred = m;
  endtask

  task automatic expect_upd(input string nm, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt, input logic m);
    check({nm, "_update"}, 64'(update), 64'd1);
    check({nm, "_pc"}, 64'(updatePC), 64'(pc));
    check({nm, "_target"}, 64'(updateTarget), 64'(tgt));
    check({nm, "_mispred"}, 64'(mispredicted), 64'(m));
  endtask

  logic got;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drv_a(1'b0, '0, '0, 1'b0);
    drv_b(1'b0, '0, '0, 1'b0);
    cyc(3);
    rst = 1'b1;
    cyc(1);

    // Simultaneous requests: A has priority after reset
    drv_a(1'b1, 32'h000A0004, 32'h000B0004, 1'b0);
    drv_b(1'b1, 32'h000A0024, 32'h000B0024, 1'b1);
    #1;
    check("t3_a_ready", 64'(a_ready), 64'd1);
    check("t3_b_ready", 64'(b_ready), 64'd1);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    drv_b(1'b0, '0, '0, 1'b0);
    cyc(1);
    expect_upd("t3_first_a", 32'h000A0004, 32'h000B0004, 1'b0);
    cyc(1);
    expect_upd("t3_second_b", 32'h000A0024, 32'h000B0024, 1'b1);
    cyc(1);
    drv_a(1'b1, 32'h000A0008, 32'h000B0008, 1'b0);
    drv_b(1'b1, 32'h000A0028, 32'h000B0028, 1'b0);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    drv_b(1'b0, '0, '0, 1'b0);
    cyc(1);
    expect_upd("t3_pair2_b_first", 32'h000A0028, 32'h000B0028, 1'b0);
    cyc(1);
    expect_upd("t3_pair2_a_second", 32'h000A0008, 32'h000B0008, 1'b0);
    cyc(2);

    // Single update from A
    drv_a(1'b1, 32'h000A0000, 32'h000B0000, 1'b0);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    check("t2_n1_update", 64'(update), 64'd0);
    cyc(1);
    expect_upd("t2_n2", 32'h000A0000, 32'h000B0000, 1'b0);
    cyc(1);
    check("t2_n3_update", 64'(update), 64'd0);
    cyc(1);

    // Full queue under stall, then a held fifth request
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv_a(1'b1, 32'h000A0000 + 32'(4 * k), 32'h000B0000 + 32'(4 * k), 1'b0);
      cyc(1);
    end
    drv_a(1'b1, 32'h000A0010, 32'h000B0010, 1'b1);
    #1;
    check("t4_count_full", 64'(count), 64'd4);
    check("t4_a_ready_full", 64'(a_ready), 64'd0);
    check("t4_b_ready_full", 64'(b_ready), 64'd0);
    cyc(2);
    stall = 1'b0;
    cyc(1);
    expect_upd("t4_entry0", 32'h000A0000, 32'h000B0000, 1'b0);
    check("t4_held_ready", 64'(a_ready), 64'd1);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      expect_upd($sformatf("t4_entry%0d", k), 32'h000A0000 + 32'(4 * k), 32'h000B0000 + 32'(4 * k), 1'b0);
      cyc(1);
    end
    expect_upd("t4_held_entry", 32'h000A0010, 32'h000B0010, 1'b1);
    cyc(1);
    check("t4_after_update", 64'(update), 64'd0);
    cyc(1);

    // One free slot: priority returns to A after three B pushes
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_b(1'b1, 32'h000A0080 + 32'(4 * k), 32'h000B0080 + 32'(4 * k), 1'b0);
      cyc(1);
    end
    drv_a(1'b1, 32'h000A00C0, 32'h000B00C0, 1'b0);
    drv_b(1'b1, 32'h000A00D0, 32'h000B00D0, 1'b1);
    #1;
    check("t5_count3", 64'(count), 64'd3);
    check("t5_a_ready", 64'(a_ready), 64'd1);
    check("t5_b_ready", 64'(b_ready), 64'd0);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    stall = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (b_ready) got = 1'b1;
      cyc(1);
    end
    drv_b(1'b0, '0, '0, 1'b0);
    check("t5_b_accept_timeout", 64'(got), 64'd1);
    cyc(8);

    // Flush drops queued and incoming updates
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drv_a(1'b1, 32'h000A0040 + 32'(4 * k), 32'h000B0040 + 32'(4 * k), 1'b0);
      cyc(1);
    end
    flush = 1'b1;
    #1;
    check("t6_a_ready_flush", 64'(a_ready), 64'd0);
    cyc(1);
    flush = 1'b0;
    stall = 1'b0;
    drv_a(1'b0, '0, '0, 1'b0);
    check("t6_count_after_flush", 64'(count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("t6_no_update", 64'(update), 64'd0);
      cyc(1);
    end
    drv_a(1'b1, 32'h000A0100, 32'h000B0100, 1'b1);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    cyc(1);
    expect_upd("t6_post_flush", 32'h000A0100, 32'h000B0100, 1'b1);
    cyc(2);

    // Asynchronous reset mid-drain with two entries queued
    stall = 1'b1;
    drv_a(1'b1, 32'h000A0200, 32'h000B0200, 1'b1);
    drv_b(1'b1, 32'h000A0204, 32'h000B0204, 1'b0);
    cyc(1);
    drv_a(1'b0, '0, '0, 1'b0);
    drv_b(1'b0, '0, '0, 1'b0);
    check("t1_count2", 64'(count), 64'd2);
    stall = 1'b0;
    cyc(1);
    check("t1_update_before_reset", 64'(update), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t1_update_async", 64'(update), 64'd0);
    check("t1_count_async", 64'(count), 64'd0);
    cyc(2);
    rst = 1'b1;
    #1;
    check("t1_a_ready_rel", 64'(a_ready), 64'd1);
    check("t1_b_ready_rel", 64'(b_ready), 64'd1);
    check("t1_pc_rel", 64'(updatePC), 64'd0);
    check("t1_target_rel", 64'(updateTarget), 64'd0);
    check("t1_mispred_rel", 64'(mispredicted), 64'd0);
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Update scheduler for the branch target buffer (BTB) write port. Two resolution sources each present one BTB update per request: requester A is the branch unit, requester B is the jump unit. The block arbitrates between them round-robin and buffers accepted requests in a small in-order FIFO. It issues at most one update per cycle on the BTB update interface (update / updatePC / updateTarget / mispredicted), and supports stall and flush from the pipeline control.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
XLEN, 32, PC/target width.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
a_valid  input  1  requester A has an update.
a_ready  output  1  requester A accepted this cycle when a_valid && a_ready.
a_pc  input  XLEN  branch PC from A.
a_target  input  XLEN  resolved target from A.
a_mispred  input  1  misprediction flag from A.
b_valid  input  1  requester B has an update.
b_ready  output  1  requester B accepted this cycle when b_valid && b_ready.
b_pc  input  XLEN  branch PC from B.
b_target  input  XLEN  resolved target from B.
b_mispred  input  1  misprediction flag from B.
stall  input  1  hold the drain; enqueueing continues.
flush  input  1  discard all queued and incoming updates.
update  output  1  BTB write strobe, registered.
updatePC  output  XLEN  BTB write PC, registered.
updateTarget  output  XLEN  BTB write target, registered.
mispredicted  output  1  BTB FSM mispredict input, registered.
count  output  clog2(DEPTH)+1  current FIFO occupancy, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - update=0; updatePC=0; updateTarget=0; mispredicted=0; count=0.
  - Read/write pointers cleared; round-robin priority set to A.
  - Takes effect immediately, including mid-drain.
- Free-slot count: free = DEPTH - count, using the registered count only. The pop in the same cycle is not credited, so there is no ready/pop combinational path.
- Acceptance (combinational):
  - flush=1: a_ready=b_ready=0.
  - free>=2: a_ready=b_ready=1.
  - free==1: only the priority requester gets ready=1. If the priority requester's valid is 0, the other requester gets ready=1.
  - free==0: both ready=0.
  - A requester's ready never depends on its own valid.
- Push ordering:
  - Both accepted in the same cycle: the priority requester is written first (older), the other second.
  - Entry stores {pc, target, mispred}.
- Priority: flips to the other requester at the edge where the current priority requester is accepted. Otherwise it is unchanged.
- Drain:
  - Pop condition at an edge: count>0 && !stall && !flush.
  - On pop: update<=1, and updatePC/updateTarget/mispredicted <= head entry.
  - Otherwise: update<=0, and the data outputs hold their last values.
- Latency and throughput:
  - Request accepted in cycle N is written at the end of N.
  - With an empty queue and no stall, update=1 in cycle N+2.
  - Sustained throughput is one update per cycle.
- Occupancy: count_next = count + pushes(0..2) - pop(0..1). Push and pop in the same cycle are legal, including when count==DEPTH-1 and two are pushed with one popped is not possible, because free==1 limits pushes to 1. Overflow and underflow are impossible by construction.
- Flush:
  - At the edge: count<=0, pointers cleared, update<=0.
  - Requests present in the flush cycle are dropped (ready=0).
  - Priority is retained.
  - Flush has precedence over stall.
- Stall: no pop and update<=0. Pushes continue until full.
- Pointers wrap modulo DEPTH.

Test Plan:
1. Reset:
   - Stimulus: assert rst=0 mid-operation with 2 entries queued.
   - Response: update=0 and count=0 immediately. After release, a_ready=b_ready=1 and all data outputs are 0.
2. Single update:
   - Stimulus: A pushes pc=0x000A0000, target=0x000B0000, mispred=0 in cycle N.
   - Response: update=1 only in N+2, with updatePC=0x000A0000, updateTarget=0x000B0000, mispredicted=0; update=0 in N+3.
3. Simultaneous requests:
   - Stimulus: empty queue; A (0x000A0004→0x000B0004) and B (0x000A0024→0x000B0024, mispred=1) both valid in cycle N.
   - Response: both accepted. Updates appear in N+2 (A) and N+3 (B, mispredicted=1).
   - Follow-up: the next simultaneous pair produces B's update first.
4. Full queue:
   - Stimulus: stall=1; push 4 entries (pc 0x000A0000+4k).
   - Response: count=4 and both readies 0; a 5th A request is held. After stall=0, 4 back-to-back updates appear in order, then the held entry, with no gaps.
5. One free slot:
   - Stimulus: count=3 (stall=1), priority=A, both valid.
   - Response: only A accepted. B is accepted in a later cycle once free>0.
6. Flush:
   - Stimulus: 3 entries queued with a_valid=1 and flush=1 for one cycle.
   - Response: a_ready=0, count=0 next cycle, no update pulse follows. A new push afterwards produces an update 2 cycles later.
